// File: rtl/palette_ram_dp.sv
// palette_ram_dp: dual-port palette RAM with byte enables and a built-in clear engine.
//
// After reset, or after a clr_req pulse, the clear engine writes zero to every word
// in address order, one word per cycle. Port requests are ignored while the clear runs.
// Once the clear finishes, both ports accept one access per cycle with no backpressure.
//
// Parameters
//   DATA_W  word width in bits, a multiple of 16
//   ADDR_W  word address width; depth is 2**ADDR_W
//   RD_LAT  read latency in cycles, 1 or 2
//
// Ports
//   clka                 sole clock, rising edge
//   rsta                 synchronous active-high reset
//   clr_req              one-cycle pulse that starts a memory clear
//   init_busy            high while the clear engine runs
//   a_req / b_req        access request
//   a_we / b_we          1 = write, 0 = read
//   a_be / b_be          byte-lane write enables
//   a_byte               port A access is an 8-bit CPU store
//   a_addr / b_addr      word address
//   a_din / b_din        write data
//   a_dout / b_dout      read data, holds between reads
//   a_valid / b_valid    one-cycle pulse qualifying dout
//
// Build option
//   PALRAM_BYTE_DUP_EN   when defined, a port A byte store (a_byte=1 with a one-hot a_be)
//                        writes the byte into both lanes of its 16-bit halfword.
module palette_ram_dp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  clr_req,
  output logic                  init_busy,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic                  a_byte,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W-1:0]     a_din,
  output logic [DATA_W-1:0]     a_dout,
  output logic                  a_valid,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W-1:0]     b_din,
  output logic [DATA_W-1:0]     b_dout,
  output logic                  b_valid
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StClear, StRun} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                run;
  logic                a_rd, b_rd, a_wr, b_wr;
  logic [NB-1:0]       a_be_eff;
  logic [DATA_W-1:0]   a_din_eff;

  assign run  = (state_q == StRun);
  assign a_rd = run && a_req && !a_we;
  assign b_rd = run && b_req && !b_we;
  assign a_wr = run && a_req && a_we;
  assign b_wr = run && b_req && b_we;

  // Clear FSM; init_busy is registered alongside the state.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q    <= StClear;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (&clr_addr_q) begin
            state_q <= StRun;
            busy_q  <= 1'b0;
          end
        end
        StRun: begin
          if (clr_req) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          state_q    <= StClear;
          clr_addr_q <= '0;
          busy_q     <= 1'b1;
        end
      endcase
    end
  end

  assign init_busy = busy_q;

  // Effective port A enables and data, after optional byte duplication.
`ifdef PALRAM_BYTE_DUP_EN
  always_comb begin
    a_be_eff  = a_be;
    a_din_eff = a_din;
    if (a_byte && $onehot(a_be)) begin
      for (int k = 0; k < NB; k++) begin
        if (a_be[k]) begin
          a_be_eff  = NB'(3) << ((k / 2) * 2);
          a_din_eff = {NB{a_din[8*k +: 8]}};
        end
      end
    end
  end
`else
  logic unused_a_byte;
  assign unused_a_byte = a_byte;
  assign a_be_eff      = a_be;
  assign a_din_eff     = a_din;
`endif

  // Memory array. Port A lanes are written after port B so A wins on a shared address.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      if (state_q == StClear) begin
        mem[clr_addr_q] <= '0;
      end else begin
        if (b_wr) begin
          for (int i = 0; i < NB; i++) begin
            if (b_be[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
          end
        end
        if (a_wr) begin
          for (int i = 0; i < NB; i++) begin
            if (a_be_eff[i]) mem[a_addr][8*i +: 8] <= a_din_eff[8*i +: 8];
          end
        end
      end
    end
  end

  // First read stage: samples the pre-write contents (read-first across ports).
  logic [DATA_W-1:0] a_d1_q, b_d1_q;
  logic              a_v1_q, b_v1_q;

  always_ff @(posedge clka) begin
    if (rsta) begin
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      a_d1_q <= '0;
      b_d1_q <= '0;
    end else begin
      a_v1_q <= a_rd;
      b_v1_q <= b_rd;
      if (a_rd) a_d1_q <= mem[a_addr];
      if (b_rd) b_d1_q <= mem[b_addr];
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] a_d2_q, b_d2_q;
    logic              a_v2_q, b_v2_q;

    always_ff @(posedge clka) begin
      if (rsta) begin
        a_v2_q <= 1'b0;
        b_v2_q <= 1'b0;
        a_d2_q <= '0;
        b_d2_q <= '0;
      end else begin
        a_v2_q <= a_v1_q;
        b_v2_q <= b_v1_q;
        if (a_v1_q) a_d2_q <= a_d1_q;
        if (b_v1_q) b_d2_q <= b_d1_q;
      end
    end

    assign a_dout  = a_d2_q;
    assign b_dout  = b_d2_q;
    assign a_valid = a_v2_q;
    assign b_valid = b_v2_q;
  end else begin : g_lat1
    assign a_dout  = a_d1_q;
    assign b_dout  = b_d1_q;
    assign a_valid = a_v1_q;
    assign b_valid = b_v1_q;
  end

endmodule

// File: tb/tb_palette_ram_dp.sv
// Bench for palette_ram_dp: one RD_LAT=1 and one RD_LAT=2 instance share all inputs
// and are compared every cycle against a word-array reference model.
module tb_palette_ram_dp;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned DEPTH  = 256;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic              rsta, clr_req;
  logic              a_req, a_we, a_byte, b_req, b_we;
  logic [NB-1:0]     a_be, b_be;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [DATA_W-1:0] a_din, b_din;

  logic              busy1, busy2;
  logic [DATA_W-1:0] a_dout1, b_dout1, a_dout2, b_dout2;
  logic              a_valid1, b_valid1, a_valid2, b_valid2;

  palette_ram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1)) u_dut1 (
    .clka(clka), .rsta(rsta), .clr_req(clr_req), .init_busy(busy1),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_byte(a_byte), .a_addr(a_addr),
    .a_din(a_din), .a_dout(a_dout1), .a_valid(a_valid1),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_din(b_din), .b_dout(b_dout1), .b_valid(b_valid1)
  );

  palette_ram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2)) u_dut2 (
    .clka(clka), .rsta(rsta), .clr_req(clr_req), .init_busy(busy2),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_byte(a_byte), .a_addr(a_addr),
    .a_din(a_din), .a_dout(a_dout2), .a_valid(a_valid2),
    .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
    .b_din(b_din), .b_dout(b_dout2), .b_valid(b_valid2)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
  endtask

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                clear_left = DEPTH;
  logic              exp_busy;
  logic              exp_av1, exp_bv1, exp_av2, exp_bv2;
  logic [DATA_W-1:0] exp_ad1, exp_bd1, exp_ad2, exp_bd2;
  logic              prev_av, prev_bv;
  logic [DATA_W-1:0] prev_ad, prev_bd;
  logic              any_valid;

  // Apply the current inputs to the model as of the coming clock edge.
  task automatic model_step();
    logic              nv_a, nv_b;
    logic [DATA_W-1:0] nd_a, nd_b, wd;
    logic [NB-1:0]     wbe;
    nv_a = 1'b0; nv_b = 1'b0; nd_a = '0; nd_b = '0;
    if (rsta) begin
      clear_left = DEPTH;
      exp_busy = 1'b1;
      exp_av1 = 0; exp_bv1 = 0; exp_av2 = 0; exp_bv2 = 0;
      exp_ad1 = 0; exp_bd1 = 0; exp_ad2 = 0; exp_bd2 = 0;
      prev_av = 0; prev_bv = 0; prev_ad = 0; prev_bd = 0;
      return;
    end
    if (clear_left > 0) begin
      m_mem[DEPTH - clear_left] = '0;
      clear_left--;
    end else begin
      if (a_req && !a_we) begin nv_a = 1'b1; nd_a = m_mem[a_addr]; end
      if (b_req && !b_we) begin nv_b = 1'b1; nd_b = m_mem[b_addr]; end
      if (b_req && b_we)
        for (int i = 0; i < NB; i++)
          if (b_be[i]) m_mem[b_addr][8*i +: 8] = b_din[8*i +: 8];
      if (a_req && a_we) begin
        wbe = a_be;
        wd  = a_din;
`ifdef PALRAM_BYTE_DUP_EN
        if (a_byte && $countones(a_be) == 1) begin
          int k;
          k = 0;
          for (int i = 0; i < NB; i++) if (a_be[i]) k = i;
          wbe = '0;
          wbe[(k / 2) * 2]     = 1'b1;
          wbe[(k / 2) * 2 + 1] = 1'b1;
          wd  = {NB{a_din[8*k +: 8]}};
        end
`endif
        for (int i = 0; i < NB; i++)
          if (wbe[i]) m_mem[a_addr][8*i +: 8] = wd[8*i +: 8];
      end
      if (clr_req) clear_left = DEPTH;
    end
    exp_busy = (clear_left > 0);
    exp_av2 = prev_av; if (prev_av) exp_ad2 = prev_ad;
    exp_bv2 = prev_bv; if (prev_bv) exp_bd2 = prev_bd;
    exp_av1 = nv_a;    if (nv_a) exp_ad1 = nd_a;
    exp_bv1 = nv_b;    if (nv_b) exp_bd1 = nd_b;
    prev_av = nv_a; prev_ad = nd_a;
    prev_bv = nv_b; prev_bd = nd_b;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clka);
    #1;
    check("busy_l1", busy1, exp_busy);
    check("busy_l2", busy2, exp_busy);
    check("a_valid_l1", a_valid1, exp_av1);
    check("b_valid_l1", b_valid1, exp_bv1);
    check("a_valid_l2", a_valid2, exp_av2);
    check("b_valid_l2", b_valid2, exp_bv2);
    check("a_dout_l1", a_dout1, exp_ad1);
    check("b_dout_l1", b_dout1, exp_bd1);
    check("a_dout_l2", a_dout2, exp_ad2);
    check("b_dout_l2", b_dout2, exp_bd2);
    any_valid = any_valid | a_valid1 | b_valid1 | a_valid2 | b_valid2;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; a_be = '0; a_byte = 0; a_addr = '0; a_din = '0;
    b_req = 0; b_we = 0; b_be = '0; b_addr = '0; b_din = '0;
    clr_req = 0;
  endtask

  task automatic rand_ports();
    a_req  = $urandom_range(0, 1);
    a_we   = $urandom_range(0, 1);
    a_be   = NB'($urandom);
    a_byte = $urandom_range(0, 1);
    a_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
    a_din  = $urandom;
    b_req  = $urandom_range(0, 1);
    b_we   = $urandom_range(0, 1);
    b_be   = NB'($urandom);
    b_addr = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 7));
    b_din  = $urandom;
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    idle();
    while (busy1 && guard < 400) begin
      guard++;
      cycle();
    end
    check(tag, busy1, 1'b0);
  endtask

  initial begin
    int cnt;
    logic [31:0] exp_dup;
    rsta = 1'b1;
    idle();
    any_valid = 1'b0;

    // Reset state
    repeat (3) cycle();
    check("rst_busy", busy1, 1'b1);
    check("rst_dout", a_dout2, 32'h0);

    // Power-up clear takes exactly DEPTH cycles
    rsta = 1'b0;
    cnt  = 0;
    while (busy1 && cnt < 300) begin
      cnt++;
      cycle();
    end
    check("busy_len", cnt, 256);
    a_req = 1; a_addr = 8'hFF;
    cycle();
    idle();
    check("rd_ff_valid", a_valid1, 1'b1);
    check("rd_ff_data", a_dout1, 32'h0);

    // Simple write then read
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 8'h10; a_din = 32'hDEADBEEF;
    cycle();
    idle(); a_req = 1; a_addr = 8'h10;
    cycle();
    idle();
    check("wr_rd_valid", a_valid1, 1'b1);
    check("wr_rd_data", a_dout1, 32'hDEADBEEF);
    cycle();
    check("wr_rd_l2", a_dout2, 32'hDEADBEEF);
    check("hold_valid", a_valid1, 1'b0);
    check("hold_data", a_dout1, 32'hDEADBEEF);

    // Same-address dual write: A lanes win
    a_req = 1; a_we = 1; a_be = 4'h3; a_addr = 8'h20; a_din = 32'h11111111;
    b_req = 1; b_we = 1; b_be = 4'hF; b_addr = 8'h20; b_din = 32'h22222222;
    cycle();
    idle(); a_req = 1; a_addr = 8'h20;
    cycle();
    idle();
    check("collide", a_dout1, 32'h22221111);

    // Byte store duplication
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 8'h05; a_din = 32'h0;
    cycle();
    a_be = 4'h4; a_byte = 1; a_din = 32'h00AB0000;
    cycle();
    idle(); a_req = 1; a_addr = 8'h05;
    cycle();
    idle();
`ifdef PALRAM_BYTE_DUP_EN
    exp_dup = 32'hABAB0000;
`else
    exp_dup = 32'h00AB0000;
`endif
    check("byte_dup", a_dout1, exp_dup);

    // RD_LAT=2 read-first across ports
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 8'h30; a_din = 32'h12345678;
    cycle();
    a_din = 32'h55;
    b_req = 1; b_we = 0; b_addr = 8'h30;
    cycle();
    idle();
    cycle();
    check("rf_l2_valid", b_valid2, 1'b1);
    check("rf_l2_data", b_dout2, 32'h12345678);

    // RD_LAT=2 read followed by a write to the same address
    a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 8'h40; a_din = 32'hCAFEF00D;
    cycle();
    a_we = 0;
    cycle();
    a_we = 1; a_din = 32'h0BADBEEF;
    cycle();
    idle();
    check("pipe_hold", a_dout2, 32'hCAFEF00D);

    // Randomized traffic with rare clears and resets
    for (int n = 0; n < 1500; n++) begin
      rand_ports();
      clr_req = ($urandom_range(0, 199) == 0);
      rsta    = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rsta = 1'b0;
    wait_idle("wait_rand");

    // Fill some words so the later full-depth zero check means something
    for (int n = 0; n < 64; n++) begin
      a_req = 1; a_we = 1; a_be = 4'hF; a_addr = ADDR_W'($urandom); a_din = $urandom | 1;
      cycle();
    end

    // clr_req, then reset in the middle of the clear
    idle(); clr_req = 1;
    cycle();
    clr_req = 0;
    any_valid = 1'b0;
    for (int n = 0; n < 100; n++) begin rand_ports(); cycle(); end
    rsta = 1'b1;
    rand_ports();
    cycle();
    cycle();
    rsta = 1'b0;
    cnt  = 0;
    while (busy1 && cnt < 300) begin
      rand_ports();
      cnt++;
      cycle();
    end
    check("clr_restart_len", cnt, 256);
    check("clr_no_valid", any_valid, 1'b0);
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      a_req = 1; a_addr = ADDR_W'(i);
      b_req = 1; b_addr = ADDR_W'(DEPTH - 1 - i);
      cycle();
      check("zero_a", a_dout1, 32'h0);
      check("zero_b", b_dout1, 32'h0);
    end
    idle();
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
